// File: rtl/clkgen_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// clkgen_pkg: FSM encoding and per-channel configuration type shared
// by clk_divider_bank and clkgen_channel.            Rev 1.0
// ------------------------------------------------------------------
package clkgen_pkg;

  // Config fields are carried at their widest legal size; narrower
  // DIV_W instances zero-extend into them.
  localparam int CFG_W = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

  typedef struct packed {
    logic             en;
    logic [CFG_W-1:0] div;
    logic [CFG_W:0]   high;
    logic [CFG_W-1:0] phase;
  } chan_cfg_t;

  function automatic chan_cfg_t default_cfg(input logic [CFG_W-1:0] div,
                                            input logic [CFG_W:0]   high);
    chan_cfg_t c;
    c.en    = 1'b1;
    c.div   = div;
    c.high  = high;
    c.phase = '0;
    return c;
  endfunction

  localparam chan_cfg_t CFG_DEFAULT = '{en: 1'b1, div: 32'd5, high: 33'd3, phase: 32'd0};

endpackage
`default_nettype wire

// File: rtl/clkgen_channel.sv
`default_nettype none
// ------------------------------------------------------------------
// clkgen_channel: one integer-divided output (config regs, counter,
// compare and registered outclk/tick).                Rev 1.0
// ------------------------------------------------------------------
module clkgen_channel
  import clkgen_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int DEFAULT_DIV  = 5,
  parameter int DEFAULT_HIGH = 3
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             wr,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W:0]   wr_high,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             outclk,
  output logic             tick
);

  chan_cfg_t        cfg_q, cfg_d, cfg_use;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             outclk_q, outclk_d;
  logic             tick_q, tick_d;

  always_comb begin
    cfg_use = cfg_q;
    if (wr) begin
      cfg_use.en    = wr_en;
      cfg_use.div   = CFG_W'(wr_div);
      cfg_use.high  = (CFG_W+1)'(wr_high);
      cfg_use.phase = CFG_W'(wr_phase);
    end
    cfg_d = cfg_use;
  end

  // A restart loads the phase of the config being written this cycle.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart) begin
      cnt_d = cfg_use.en ? DIV_W'(cfg_use.phase) : '0;
    end else if (!cfg_q.en) begin
      cnt_d = '0;
    end else if (CFG_W'(cnt_q) == cfg_q.div) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    outclk_d = cfg_q.en && ((CFG_W+1)'(cnt_q) < cfg_q.high);
    tick_d   = cfg_q.en && (cnt_q == '0) && (cfg_q.high != '0);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= default_cfg(CFG_W'(DEFAULT_DIV), (CFG_W+1)'(DEFAULT_HIGH));
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      tick_q   <= tick_d;
    end
  end

  assign outclk = outclk_q;
  assign tick   = tick_q;

endmodule
`default_nettype wire

// File: rtl/clk_divider_bank.sv
`default_nettype none
// ------------------------------------------------------------------
// clk_divider_bank: NUM_CLOCKS programmable divided clocks from refclk
// with valid/ready reconfiguration and a settle-based lock flag. Rev 1.0
// ------------------------------------------------------------------
module clk_divider_bank
  import clkgen_pkg::*;
#(
  parameter int NUM_CLOCKS    = 2,
  parameter int DIV_W         = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int DEFAULT_DIV   = 5,
  parameter int DEFAULT_HIGH  = 3,
  localparam int CHAN_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W:0]        cfg_high,
  input  logic [DIV_W-1:0]      cfg_phase,
  input  logic                  cfg_en,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CHAN_W:0]   CHAN_LIMIT  = (CHAN_W+1)'(NUM_CLOCKS);

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               locked_q, locked_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [CHAN_W-1:0]  pchan_q, pchan_d;
  logic               pen_q, pen_d;
  logic [DIV_W-1:0]   pdiv_q, pdiv_d;
  logic [DIV_W:0]     phigh_q, phigh_d;
  logic [DIV_W-1:0]   pphase_q, pphase_d;
  logic               req, bad, accept, reload;

  always_comb begin
    bad    = (cfg_phase > cfg_div)
          || (cfg_high > ({1'b0, cfg_div} + 1'b1))
          || ({1'b0, cfg_chan} >= CHAN_LIMIT);
    req    = cfg_valid && ready_q;
    accept = req && !bad;
    err_d  = req && bad;
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_SETTLE: begin
        if (accept) begin
          state_d = ST_RELOAD;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_LOCKED;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          state_d = ST_RELOAD;
        end
      end
      ST_RELOAD: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      default: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
    endcase
    locked_d = (state_d == ST_LOCKED);
    ready_d  = (state_d != ST_RELOAD);
  end

  // The accepted request is parked here until the RELOAD cycle applies it.
  always_comb begin
    pchan_d  = pchan_q;
    pen_d    = pen_q;
    pdiv_d   = pdiv_q;
    phigh_d  = phigh_q;
    pphase_d = pphase_q;
    if (accept) begin
      pchan_d  = cfg_chan;
      pen_d    = cfg_en;
      pdiv_d   = cfg_div;
      phigh_d  = cfg_high;
      pphase_d = cfg_phase;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      locked_q <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      pchan_q  <= '0;
      pen_q    <= 1'b0;
      pdiv_q   <= '0;
      phigh_q  <= '0;
      pphase_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      pchan_q  <= pchan_d;
      pen_q    <= pen_d;
      pdiv_q   <= pdiv_d;
      phigh_q  <= phigh_d;
      pphase_q <= pphase_d;
    end
  end

  assign reload    = (state_q == ST_RELOAD);
  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign locked    = locked_q;

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    clkgen_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_chan (
      .refclk  (refclk),
      .rst_n   (rst_n),
      .restart (reload),
      .wr      (reload && (pchan_q == CHAN_W'(i))),
      .wr_en   (pen_q),
      .wr_div  (pdiv_q),
      .wr_high (phigh_q),
      .wr_phase(pphase_q),
      .outclk  (outclk[i]),
      .tick    (tick[i])
    );
  end

endmodule
`default_nettype wire
